// File: rtl/seq_alu_pkg.sv
// Shared opcode constants and iterative-unit state encoding for seq_alu.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_NOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_MULT  = 4'd8;
    localparam logic [3:0] OP_DIV   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_SLTU  = 4'd11;
    localparam logic [3:0] OP_MULTU = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes.
// One step per cycle for WIDTH cycles, then a FIX cycle applies the result signs.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             launch,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             fin,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             res_ovf
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_e        state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             div_q, div_d;
    logic             neg_hi_q, neg_hi_d;
    logic             neg_lo_q, neg_lo_d;
    logic             ovf_q, ovf_d;

    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [2*WIDTH-1:0] prod_neg;

    assign sign_a    = op_signed & opa[WIDTH-1];
    assign sign_b    = op_signed & opb[WIDTH-1];
    assign mag_a     = sign_a ? -opa : opa;
    assign mag_b     = sign_b ? -opb : opb;
    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    assign prod_neg  = -{acc_hi_q, acc_lo_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        div_d    = div_q;
        neg_hi_d = neg_hi_q;
        neg_lo_d = neg_lo_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    // acc_lo holds the multiplier / dividend, opnd the multiplicand / divisor
                    acc_hi_d = '0;
                    acc_lo_d = mag_a;
                    opnd_d   = mag_b;
                    cnt_d    = '0;
                    div_d    = op_div;
                    neg_lo_d = sign_a ^ sign_b;
                    if (op_div) begin
                        neg_hi_d = sign_a;
                        ovf_d    = op_signed && (opa == MOST_NEG) && (opb == '1);
                        state_d  = ST_DIV;
                    end else begin
                        neg_hi_d = sign_a ^ sign_b;
                        ovf_d    = 1'b0;
                        state_d  = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_FIX;
                end
            end
            ST_DIV: begin
                if (!div_diff[WIDTH+1]) begin
                    acc_hi_d = div_diff[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi_d = div_shift[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        res_hi = acc_hi_q;
        res_lo = acc_lo_q;
        if (div_q) begin
            if (neg_hi_q) res_hi = -acc_hi_q;
            if (neg_lo_q) res_lo = -acc_lo_q;
        end else if (neg_hi_q) begin
            {res_hi, res_lo} = prod_neg;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign fin     = (state_q == ST_FIX);
    assign res_ovf = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            div_q    <= 1'b0;
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            div_q    <= div_d;
            neg_hi_q <= neg_hi_d;
            neg_lo_q <= neg_lo_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops registered on the start edge, MULT/DIV via seq_alu_muldiv.
// start is ignored while busy; alu_done pulses for one cycle when a result lands.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_srcA,
    input  logic [WIDTH-1:0] alu_srcB,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             overflow,
    output logic             alu_zero,
    output logic             busy,
    output logic             alu_done
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] alu_result_q, alu_result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             overflow_q, overflow_d;
    logic             alu_done_q, alu_done_d;

    logic             md_busy, md_fin, md_ovf, md_launch;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic             accept, op_md, op_div, op_signed, div_zero;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_result;
    logic             sc_ovf;

    assign accept    = start & ~md_busy;
    assign op_md     = is_muldiv(alu_control);
    assign op_div    = (alu_control == OP_DIV) || (alu_control == OP_DIVU);
    assign op_signed = (alu_control == OP_MULT) || (alu_control == OP_DIV);
    assign div_zero  = op_div && (alu_srcB == '0);
    assign md_launch = accept & op_md & ~div_zero;
    assign shamt     = alu_srcA[SHW-1:0];

    always_comb begin
        sc_result = '0;
        sc_ovf    = 1'b0;
        case (alu_control)
            OP_ADD: begin
                sc_result = alu_srcA + alu_srcB;
                sc_ovf    = (alu_srcA[WIDTH-1] == alu_srcB[WIDTH-1]) &&
                            (sc_result[WIDTH-1] != alu_srcA[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = alu_srcA - alu_srcB;
                sc_ovf    = (alu_srcA[WIDTH-1] != alu_srcB[WIDTH-1]) &&
                            (sc_result[WIDTH-1] != alu_srcA[WIDTH-1]);
            end
            OP_AND:  sc_result = alu_srcA & alu_srcB;
            OP_OR:   sc_result = alu_srcA | alu_srcB;
            OP_NOR:  sc_result = ~(alu_srcA | alu_srcB);
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, $signed(alu_srcA) < $signed(alu_srcB)};
            OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, alu_srcA < alu_srcB};
            OP_SLL:  sc_result = alu_srcB << shamt;
            OP_SRL:  sc_result = alu_srcB >> shamt;
            OP_SRA:  sc_result = $signed(alu_srcB) >>> shamt;
            default: begin
                sc_result = '0;
                sc_ovf    = 1'b0;
            end
        endcase
    end

    always_comb begin
        alu_result_d = alu_result_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        overflow_d   = overflow_q;
        alu_done_d   = 1'b0;
        if (md_fin) begin
            hi_d       = md_hi;
            lo_d       = md_lo;
            overflow_d = md_ovf;
            alu_done_d = 1'b1;
        end else if (accept) begin
            if (op_md) begin
                // divide by zero completes immediately; other mul/div ops finish via FIX
                if (div_zero) begin
                    hi_d       = '0;
                    lo_d       = '0;
                    overflow_d = 1'b1;
                    alu_done_d = 1'b1;
                end
            end else begin
                alu_result_d = sc_result;
                overflow_d   = sc_ovf;
                alu_done_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_q <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            overflow_q   <= 1'b0;
            alu_done_q   <= 1'b0;
        end else begin
            alu_result_q <= alu_result_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            overflow_q   <= overflow_d;
            alu_done_q   <= alu_done_d;
        end
    end

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .launch    (md_launch),
        .op_div    (op_div),
        .op_signed (op_signed),
        .opa       (alu_srcA),
        .opb       (alu_srcB),
        .busy      (md_busy),
        .fin       (md_fin),
        .res_hi    (md_hi),
        .res_lo    (md_lo),
        .res_ovf   (md_ovf)
    );

    assign alu_result = alu_result_q;
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign overflow   = overflow_q;
    assign alu_done   = alu_done_q;
    assign busy       = md_busy;
    assign alu_zero   = (alu_result_q == '0);

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32) against an arithmetic reference model.
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  alu_control = 4'd0;
    logic [31:0] alu_srcA = '0, alu_srcB = '0;
    logic [31:0] alu_result, hi, lo;
    logic        overflow, alu_zero, busy, alu_done;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_res = '0, m_hi = '0, m_lo = '0;
    logic        m_ovf = 1'b0;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
        .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_result(alu_result),
        .hi(hi), .lo(lo), .overflow(overflow), .alu_zero(alu_zero),
        .busy(busy), .alu_done(alu_done)
    );

    always #5 clk = ~clk;

    // Architectural model: updates expected visible state, returns done latency in cycles.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        longint sa, sb, ua, ub, q, r;
        logic [63:0] p;
        logic signed [31:0] bs;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        bs = b;
        lat = 0;
        case (op)
            4'd0:  begin m_res = a + b; m_ovf = (a[31] == b[31]) && (m_res[31] != a[31]); end
            4'd1:  begin m_res = a - b; m_ovf = (a[31] != b[31]) && (m_res[31] != a[31]); end
            4'd2:  begin m_res = a & b;      m_ovf = 0; end
            4'd3:  begin m_res = a | b;      m_ovf = 0; end
            4'd4:  begin m_res = ~(a | b);   m_ovf = 0; end
            4'd5:  begin m_res = (sa < sb) ? 32'd1 : 32'd0; m_ovf = 0; end
            4'd6:  begin m_res = b << a[4:0]; m_ovf = 0; end
            4'd7:  begin m_res = b >> a[4:0]; m_ovf = 0; end
            4'd10: begin m_res = bs >>> a[4:0]; m_ovf = 0; end
            4'd11: begin m_res = (ua < ub) ? 32'd1 : 32'd0; m_ovf = 0; end
            4'd8, 4'd12: begin
                p = (op == 4'd8) ? sa * sb : ua * ub;
                m_hi = p[63:32]; m_lo = p[31:0]; m_ovf = 0; lat = 33;
            end
            4'd9, 4'd13: begin
                if (b == 0) begin
                    m_hi = 0; m_lo = 0; m_ovf = 1;
                end else begin
                    q = (op == 4'd9) ? sa / sb : ua / ub;
                    r = (op == 4'd9) ? sa % sb : ua % ub;
                    p = q; m_lo = p[31:0];
                    p = r; m_hi = p[31:0];
                    m_ovf = (op == 4'd9) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
                    lat = 33;
                end
            end
            default: begin m_res = 0; m_ovf = 0; end
        endcase
    endtask

    // Launch one op; report first done sample index, busy and done sample counts.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inj_k, output int done_k, output int busy_n, output int done_n);
        @(negedge clk);
        start = 1; alu_control = op; alu_srcA = a; alu_srcB = b;
        @(posedge clk); #1;
        start = 0; alu_control = 4'($urandom); alu_srcA = $urandom; alu_srcB = $urandom;
        done_k = -1; busy_n = 0; done_n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (alu_done) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            if (k == inj_k) begin
                start = 1; alu_control = 4'd0; alu_srcA = 32'd1; alu_srcB = 32'd2;
            end else begin
                start = 0;
            end
            if (done_k >= 0 && k > done_k) break;
        end
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        checks++; if (alu_result !== 0 || hi !== 0 || lo !== 0) begin errors++;
            $display("FAIL reset_regs: got res=%h hi=%h lo=%h want all 0", alu_result, hi, lo); end
        checks++; if (overflow !== 0 || busy !== 0 || alu_done !== 0) begin errors++;
            $display("FAIL reset_flags: got ovf=%b busy=%b done=%b want 0", overflow, busy, alu_done); end
        rst = 0;
        @(negedge clk);
        checks++; if (alu_zero !== 1 || alu_done !== 0) begin errors++;
            $display("FAIL reset_release: got zero=%b done=%b want 1/0", alu_zero, alu_done); end
    endtask

    task automatic test_alu_ops();
        logic [3:0]  ops[12] = '{4'd0, 4'd8, 4'd9, 4'd13, 4'd10, 4'd5, 4'd11, 4'd9, 4'd1, 4'd14, 4'd12, 4'd15};
        logic [31:0] as[12]  = '{32'h7FFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd7, 32'd4, 32'hFFFFFFFF,
                                 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h1234, 32'hFFFFFFFF, 32'h55};
        logic [31:0] bs[12]  = '{32'd1, 32'd7, 32'd2, 32'd0, 32'h80000000, 32'd1,
                                 32'd1, 32'hFFFFFFFF, 32'd1, 32'h5678, 32'hFFFFFFFF, 32'hAA};
        logic [3:0]  op;
        logic [31:0] a, b;
        int lat, dk, bn, dn;
        for (int i = 0; i < 72; i++) begin
            if (i < 12) begin
                op = ops[i]; a = as[i]; b = bs[i];
            end else begin
                op = 4'($urandom_range(0, 15));
                a = $urandom; b = $urandom;
                if ($urandom_range(0, 3) == 0) a = {27'd0, a[4:0]};
                if ($urandom_range(0, 7) == 0) b = {28'd0, b[3:0]};
            end
            model(op, a, b, lat);
            do_op(op, a, b, -1, dk, bn, dn);
            checks++; if (alu_result !== m_res || alu_zero !== (m_res == 0)) begin errors++;
                $display("FAIL op%0d_result a=%h b=%h: got %h zero=%b want %h", op, a, b, alu_result, alu_zero, m_res); end
            checks++; if (hi !== m_hi || lo !== m_lo) begin errors++;
                $display("FAIL op%0d_hilo a=%h b=%h: got %h_%h want %h_%h", op, a, b, hi, lo, m_hi, m_lo); end
            checks++; if (overflow !== m_ovf) begin errors++;
                $display("FAIL op%0d_ovf a=%h b=%h: got %b want %b", op, a, b, overflow, m_ovf); end
            checks++; if (dk != lat || dn != 1 || bn != lat) begin errors++;
                $display("FAIL op%0d_timing: got done_at=%0d pulses=%0d busy=%0d want %0d/1/%0d", op, dk, dn, bn, lat, lat); end
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] res_before;
        int lat, dk, bn, dn;
        res_before = m_res;
        model(4'd8, 32'hFFFFFFFD, 32'd7, lat);
        do_op(4'd8, 32'hFFFFFFFD, 32'd7, 5, dk, bn, dn);
        checks++; if (alu_result !== res_before) begin errors++;
            $display("FAIL ignore_result: got %h want %h", alu_result, res_before); end
        checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin errors++;
            $display("FAIL ignore_hilo: got %h_%h want ffffffff_ffffffeb", hi, lo); end
        checks++; if (dk != 33 || dn != 1) begin errors++;
            $display("FAIL ignore_timing: got done_at=%0d pulses=%0d want 33/1", dk, dn); end
    endtask

    task automatic test_reset_mid();
        int lat, dk, bn, dn, pulses;
        @(negedge clk);
        start = 1; alu_control = 4'd9; alu_srcA = 32'hDEADBEEF; alu_srcB = 32'd3;
        @(posedge clk); #1;
        start = 0;
        repeat (10) @(negedge clk);
        rst = 1;
        #1;
        checks++; if (busy !== 0 || alu_done !== 0 || hi !== 0 || lo !== 0) begin errors++;
            $display("FAIL rst_mid: got busy=%b done=%b hi=%h lo=%h want 0", busy, alu_done, hi, lo); end
        m_res = 0; m_hi = 0; m_lo = 0; m_ovf = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        pulses = 0;
        repeat (40) begin @(negedge clk); if (alu_done || busy) pulses++; end
        checks++; if (pulses != 0) begin errors++;
            $display("FAIL rst_no_done: got %0d active samples want 0", pulses); end
        model(4'd12, 32'hFFFFFFFF, 32'd2, lat);
        do_op(4'd12, 32'hFFFFFFFF, 32'd2, -1, dk, bn, dn);
        checks++; if (hi !== 32'h1 || lo !== 32'hFFFFFFFE || dk != 33) begin errors++;
            $display("FAIL rst_then_multu: got %h_%h done_at=%0d want 00000001_fffffffe 33", hi, lo, dk); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res_before, c, d, mh, ml, addr;
        logic dn_s[36], bz_s[36];
        logic [31:0] res_s[36];
        int lat;
        c = $urandom; d = $urandom;
        res_before = m_res;
        model(4'd8, 32'h00012345, 32'hFFFF0003, lat);
        mh = m_hi; ml = m_lo;
        model(4'd0, c, d, lat);
        addr = m_res;
        @(negedge clk);
        start = 1; alu_control = 4'd8; alu_srcA = 32'h00012345; alu_srcB = 32'hFFFF0003;
        @(posedge clk); #1;
        alu_control = 4'd0; alu_srcA = c; alu_srcB = d;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            dn_s[k] = alu_done; bz_s[k] = busy; res_s[k] = alu_result;
            if (k == 33) begin
                checks++; if (hi !== mh || lo !== ml || res_s[k] !== res_before) begin errors++;
                    $display("FAIL b2b_mult: got %h_%h res=%h want %h_%h res=%h", hi, lo, res_s[k], mh, ml, res_before); end
            end
            if (k == 34) start = 0;
        end
        checks++; if (dn_s[32] !== 0 || dn_s[33] !== 1 || dn_s[34] !== 1 || dn_s[35] !== 0) begin errors++;
            $display("FAIL b2b_done: got %b%b%b%b want 0110", dn_s[32], dn_s[33], dn_s[34], dn_s[35]); end
        checks++; if (res_s[34] !== addr || bz_s[32] !== 1 || bz_s[33] !== 0 || bz_s[34] !== 0) begin errors++;
            $display("FAIL b2b_add: got res=%h busy=%b%b%b want %h 100", res_s[34], bz_s[32], bz_s[33], bz_s[34], addr); end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
